// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_mux
//  Purpose  : Registered NUM_CH:1 multiplexer with internal round-robin or
//             fixed-priority arbitration and valid/ready handshakes on both
//             the input channels and the output register.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 1,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*WIDTH-1:0]  in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  // Index width actually needed to address NUM_CH channels.
  localparam int c_sel_w_req = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // A mismatched SEL_W would silently truncate or pad the channel index,
  // so refuse to elaborate such a configuration.
  if (SEL_W != c_sel_w_req) begin : g_cfg_err
    $fatal(1, "rr_arb_mux: SEL_W does not match ceil(log2(NUM_CH))");
  end

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic [SEL_W-1:0]     r_out_sel;
  logic [SEL_W-1:0]     r_last_grant;

  logic                 w_load_en;
  logic                 w_found;
  logic [SEL_W-1:0]     w_winner;
  logic                 w_grant;
  logic [WIDTH-1:0]     w_ch_data [NUM_CH];

  // Slice the flattened input bus into one word per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // The output register may take a new word when empty or being drained;
  // this keeps one transfer per cycle with no bubble.
  assign w_load_en = !r_out_valid || out_ready;

  if (MODE == 0) begin : g_rr
    int w_rr_idx;

    // Round-robin: search from the channel after the last grant, wrapping.
    // The loop runs from the farthest candidate to the nearest so that the
    // nearest requester is the final (winning) assignment.
    always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_rr_idx = 0;
      for (int k = NUM_CH; k >= 1; k--) begin
        w_rr_idx = int'(r_last_grant) + k;
        if (w_rr_idx >= NUM_CH) begin
          w_rr_idx = w_rr_idx - NUM_CH;
        end
        if (in_valid[SEL_W'(w_rr_idx)]) begin
          w_found  = 1'b1;
          w_winner = SEL_W'(w_rr_idx);
        end
      end
    end
  end else begin : g_fp
    // Fixed priority: lowest requesting index wins (scan high to low so the
    // lowest index is the final assignment).
    always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (in_valid[SEL_W'(i)]) begin
          w_found  = 1'b1;
          w_winner = SEL_W'(i);
        end
      end
    end
  end

  // A grant is only issued when the register can load and not in reset,
  // so no source ever sees its word accepted during a reset cycle.
  assign w_grant = w_found && w_load_en && !rst;

  // One-hot accept towards the winning channel only.
  always_comb begin
    in_ready = '0;
    if (w_grant) begin
      in_ready[w_winner] = 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_last_grant <= SEL_W'(NUM_CH - 1);
    end else if (w_load_en) begin
      if (w_found) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ch_data[w_winner];
        r_out_sel   <= w_winner;
        if (MODE == 0) begin
          r_last_grant <= w_winner;
        end
      end else begin
        // Drained (or already empty) with nothing new: data/sel just hold.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb_mux
//  Purpose  : Scoreboard bench for rr_arb_mux. Two instances share clk/rst:
//             a 3-channel round-robin one and a 2-channel fixed-priority one.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  iv   [2];
  logic [95:0] id   [2];
  logic        ordy [2];

  logic [2:0]  rr_rdy;
  logic [1:0]  fp_rdy;
  logic        rr_ov, fp_ov;
  logic [31:0] rr_od, fp_od;
  logic [1:0]  rr_os;
  logic        fp_os;

  rr_arb_mux #(.WIDTH(32), .NUM_CH(3), .SEL_W(2), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_data(id[0]), .in_ready(rr_rdy),
    .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_os), .out_ready(ordy[0])
  );

  rr_arb_mux #(.WIDTH(32), .NUM_CH(2), .SEL_W(1), .MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .in_valid(iv[1][1:0]), .in_data(id[1][63:0]), .in_ready(fp_rdy),
    .out_valid(fp_ov), .out_data(fp_od), .out_sel(fp_os), .out_ready(ordy[1])
  );

  typedef struct {
    logic [31:0] data;
    int          sel;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  // Reference state: occupancy of the output register, round-robin pointer,
  // and whether out_data/out_sel are still at their reset value.
  bit  m_valid [2];
  int  m_ptr   [2];
  bit  m_zero  [2];
  bit  m_init = 1'b0;

  function automatic int nch(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  function automatic int mode(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic logic [2:0] dut_rdy(input int d);
    return (d == 0) ? rr_rdy : {1'b0, fp_rdy};
  endfunction

  function automatic logic dut_ov(input int d);
    return (d == 0) ? rr_ov : fp_ov;
  endfunction

  function automatic logic [31:0] dut_od(input int d);
    return (d == 0) ? rr_od : fp_od;
  endfunction

  function automatic int dut_os(input int d);
    return (d == 0) ? int'(rr_os) : int'(fp_os);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic q_push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic q_flush(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic check(input bit ok, input string name, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, d, $time, act, exp);
    end
  endtask

  // Which channel the arbitration rules say wins, or -1 for none.
  function automatic int ref_winner(input logic [2:0] v, input int p,
                                    input int n, input int md);
    if (md == 1) begin
      for (int c = 0; c < n; c++) if (v[c]) return c;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (p + k) % n;
        if (v[c]) return c;
      end
    end
    return -1;
  endfunction

  // ---------------- reference model / expectation producer ----------------
  logic [2:0] a_v;
  logic [2:0] a_exp_rdy;
  bit         a_load;
  int         a_w;
  exp_t       a_e;

  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      a_v = iv[d] & ((d == 0) ? 3'b111 : 3'b011);
      if (m_init) begin
        check(dut_ov(d) == m_valid[d], "out_valid", d,
              64'(dut_ov(d)), 64'(m_valid[d]));
        if (m_zero[d]) begin
          check((dut_od(d) == 32'd0) && (dut_os(d) == 0), "reset_data_sel", d,
                {dut_od(d), 32'(dut_os(d))}, 64'd0);
        end
      end
      if (rst) begin
        check(dut_rdy(d) == 3'b000, "in_ready_in_reset", d, 64'(dut_rdy(d)), 64'd0);
        m_valid[d] = 1'b0;
        m_ptr[d]   = nch(d) - 1;
        m_zero[d]  = 1'b1;
        q_flush(d);
      end else if (m_init) begin
        a_load    = !m_valid[d] || ordy[d];
        a_w       = a_load ? ref_winner(a_v, m_ptr[d], nch(d), mode(d)) : -1;
        a_exp_rdy = (a_w >= 0) ? 3'(1 << a_w) : 3'b000;
        check(dut_rdy(d) == a_exp_rdy, "in_ready", d, 64'(dut_rdy(d)), 64'(a_exp_rdy));
        if (a_w >= 0) begin
          a_e.data = id[d][a_w*32 +: 32];
          a_e.sel  = a_w;
          q_push(d, a_e);
          m_valid[d] = 1'b1;
          m_zero[d]  = 1'b0;
          if (mode(d) == 0) m_ptr[d] = a_w;
        end else if (a_load) begin
          m_valid[d] = 1'b0;
        end
      end
    end
    if (rst) m_init = 1'b1;
  end

  // ---------------- monitor: compares presented words ----------------
  exp_t b_e;

  always @(negedge clk) begin
    if (!rst && m_init) begin
      for (int d = 0; d < 2; d++) begin
        if (dut_ov(d)) begin
          if (q_size(d) == 0) begin
            check(1'b0, "unexpected_out_valid", d, {dut_od(d), 32'(dut_os(d))}, 64'd0);
          end else begin
            b_e = q_front(d);
            check((dut_od(d) == b_e.data) && (dut_os(d) == b_e.sel),
                  ordy[d] ? "out_word" : "held_word", d,
                  {dut_od(d), 32'(dut_os(d))}, {b_e.data, 32'(b_e.sel)});
            if (ordy[d]) q_pop(d);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    iv   = '{3'b111, 3'b011};
    ordy = '{1'b1, 1'b1};
    id   = '{{$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}};
    repeat (3) step();

    // Release: everything valid, channel 0 must be granted first.
    rst = 1'b0;
    step();

    // Only channel 1 valid.
    iv = '{3'b010, 3'b010};
    id = '{{32'd0, 32'hA5A5_0001, 32'd0}, {32'd0, 32'hA5A5_0001, 32'd0}};
    step();

    // Continuous requests with data 10/20/30.
    iv = '{3'b111, 3'b011};
    id = '{{32'd30, 32'd20, 32'd10}, {32'd0, 32'd20, 32'd10}};
    repeat (6) step();

    // Load 0x1234 from channel 0, then stall the output for 3 cycles.
    iv = '{3'b001, 3'b001};
    id = '{{32'd30, 32'd20, 32'h1234}, {32'd0, 32'd20, 32'h1234}};
    step();
    iv   = '{3'b111, 3'b011};
    ordy = '{1'b0, 1'b0};
    repeat (3) step();
    ordy = '{1'b1, 1'b1};
    repeat (2) step();

    // Drop channel 0: fixed-priority instance must now serve channel 1.
    iv = '{3'b110, 3'b010};
    repeat (2) step();

    // Reset in the middle of a stream.
    iv = '{3'b111, 3'b011};
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Randomised traffic with backpressure and occasional reset.
    repeat (400) begin
      iv[0]   = 3'($urandom_range(0, 7));
      iv[1]   = {1'b0, 2'($urandom_range(0, 3))};
      id[0]   = {$urandom, $urandom, $urandom};
      id[1]   = {$urandom, $urandom, $urandom};
      ordy[0] = ($urandom_range(0, 9) < 7);
      ordy[1] = ($urandom_range(0, 9) < 7);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end

    // Drain.
    rst  = 1'b0;
    iv   = '{3'b000, 3'b000};
    ordy = '{1'b1, 1'b1};
    repeat (4) step();

    for (int d = 0; d < 2; d++) begin
      check(q_size(d) == 0, "queue_drained", d, 64'(q_size(d)), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
